core_run_control: RTL and testbench
===================================

// Module: core_run_control
// PURPOSE
//  Per-core run/halt/step/jump controller with retired-instruction counter and PC breakpoints,
//  generalising the fixed halt/run/step/jump register set. One instance sits between the
//  peripheral bus slice of a core and the RV32I pipeline. Debug software halts, single- or
//  multi-steps, redirects the core and traps on breakpoint addresses.
// PARAMETERS
//  PC_WIDTH          32     width of PC/breakpoint addresses
//  BREAKPOINT_COUNT  2      number of PC breakpoints (1..8)
//  STEP_WIDTH        16     width of multi-step counter
// PORTS
//  clk                    in   1         core clock
//  rst                    in   1         asynchronous reset, active high
//  peripheralEnable       in   1         bus access strobe (one cycle per access)
//  peripheralWriteEnable  in   1         1 write, 0 read
//  peripheralAddress      in   4         word register index
//  peripheralDataWrite    in   32        write data
//  peripheralDataRead     out  32        read data, valid cycle after strobe
//  peripheralBusy         out  1         high only during the strobe cycle
//  coreRetire             in   1         core retired one instruction this cycle
//  coreRetirePC           in   PC_WIDTH  PC of retiring instruction
//  coreNextPC             in   PC_WIDTH  core's current fetch PC
//  coreHalt               out  1         core must retire nothing while high
//  coreJump               out  1         one-cycle redirect pulse
//  coreJumpAddress        out  PC_WIDTH  redirect target
//  breakpointIrq          out  1         one-cycle pulse on breakpoint halt
// BEHAVIOUR
//  Registers (word index): 0 CONFIG, 1 STEP, 2 JUMP, 3 PC(ro), 4 INSTRET_LO, 5 INSTRET_HI,
//   6 BP_CTRL, 8+i BP_ADDR[i]; unmapped reads 0, writes ignored.
//  Reset: state HALTED, counters 0, BP enables/hits 0, BP_ADDR 0, coreHalt=1, coreJump=0,
//   coreJumpAddress=0, breakpointIrq=0, peripheralDataRead=0, peripheralBusy=0.
//  FSM HALTED/RUNNING/STEPPING:
//   HALTED  -> RUNNING on CONFIG write bit0=1; -> STEPPING on STEP write (N=0 treated as 1).
//   RUNNING -> HALTED on CONFIG write bit0=0, or retire matching an enabled breakpoint.
//   STEPPING-> HALTED when remaining reaches 0 (decrement per retire), on breakpoint, or
//              CONFIG bit0=0 write.
//  coreHalt = (state==HALTED) | stopNow; stopNow is combinational from the terminating retire
//   (breakpoint match or last step), so no further retire follows it.
//  CONFIG read: b0 running, b1 stepping, b2 halted-by-breakpoint, b3 sticky cmdError.
//   Any CONFIG write clears b2 and b3.
//  JUMP write while HALTED: coreJump=1 next cycle, coreJumpAddress=data; otherwise ignored,
//   cmdError set. STEP write while not HALTED: ignored, cmdError set.
//  INSTRET 64-bit, +1 per retire in every state, wraps to 0; any write to 4 or 5 clears all
//   64 bits (clear wins over same-cycle retire). HI read returns the value latched on LO read.
//  BP_CTRL: [B-1:0] enables rw; [8+B-1:8] hit flags, write-1-to-clear; match on
//   coreRetire & enable & coreRetirePC==BP_ADDR; all simultaneous matches set hit bits.
//  Simultaneous events: retire counted even when same-cycle halt write; breakpoint and last
//   step on one retire -> HALTED with b2 set and breakpointIrq pulse; bus write and
//   hardware hit to same hit bit -> hit stays set.
//  Reset mid-step or mid-jump discards pending count/pulse immediately (async).
// STRUCTURE
//  Package core_debug_pkg: register index localparams, CONFIG bit positions, state encoding.
//  Sub-module core_breakpoint_match (one comparator + hit flag), generate per breakpoint.
//  Top holds FSM, step counter, INSTRET, bus decode/readback.
// TESTING
//  After reset read CONFIG -> 0, PC -> RESET PC 0x0, coreHalt=1.
//  STEP write 0 with NOP stream -> exactly one retire, PC 0x4, state HALTED;
//   STEP write 5 -> INSTRET advances by exactly 5.
//  JUMP 0x100 while halted -> coreJump pulse, PC 0x100; JUMP while running -> ignored,
//   CONFIG b3=1.
//  BP0=0x108 enabled, CONFIG run from 0x100 -> halt after 0x108 retires, CONFIG=0x4,
//   BP_CTRL hit b8=1, breakpointIrq one cycle.
//  Run 200ns, halt, INSTRET>1; run again -> INSTRET strictly larger; write LO -> reads 0.
//  Preload INSTRET 0xFFFF_FFFF_FFFF_FFFF via forced state + 1 retire -> wraps to 0;
//   assert rst while STEPPING -> immediate HALTED.

Source files
------------

// File: rtl/core_debug_pkg.sv
// Shared definitions for the per-core run/halt/step controller:
// register map, CONFIG bit positions and run-state encoding.
package core_debug_pkg;

    localparam logic [3:0] REG_CONFIG     = 4'd0;
    localparam logic [3:0] REG_STEP       = 4'd1;
    localparam logic [3:0] REG_JUMP       = 4'd2;
    localparam logic [3:0] REG_PC         = 4'd3;
    localparam logic [3:0] REG_INSTRET_LO = 4'd4;
    localparam logic [3:0] REG_INSTRET_HI = 4'd5;
    localparam logic [3:0] REG_BP_CTRL    = 4'd6;
    localparam logic [3:0] REG_BP_ADDR0   = 4'd8;

    localparam int CFG_RUNNING   = 0;
    localparam int CFG_STEPPING  = 1;
    localparam int CFG_BP_HALT   = 2;
    localparam int CFG_CMD_ERROR = 3;

    // Hit flags live in the upper byte of BP_CTRL, enables in the lower byte.
    localparam int BP_HIT_LSB = 8;

    typedef enum logic [1:0] {
        ST_HALTED   = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2
    } run_state_t;

endpackage

// File: rtl/core_breakpoint_match.sv
// One PC breakpoint: address register, enable bit, retire comparator and
// sticky hit flag (write-1-to-clear, a same-cycle hardware hit keeps it set).
module core_breakpoint_match #(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                addr_write,
    input  logic [PC_WIDTH-1:0] addr_data,
    input  logic                ctrl_write,
    input  logic                enable_data,
    input  logic                clear_data,
    input  logic                retire,
    input  logic [PC_WIDTH-1:0] retire_pc,
    output logic                match,
    output logic                enable,
    output logic                hit,
    output logic [PC_WIDTH-1:0] address
);

    assign match = retire & enable & (retire_pc == address);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            address <= '0;
            enable  <= 1'b0;
            hit     <= 1'b0;
        end else begin
            if (addr_write) begin
                address <= addr_data;
            end
            if (ctrl_write) begin
                enable <= enable_data;
            end
            if (match) begin
                hit <= 1'b1;
            end else if (ctrl_write && clear_data) begin
                hit <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/core_run_control.sv
// Per-core run/halt/step/jump controller with a 64-bit retired-instruction
// counter and a bank of PC breakpoints, driven from the peripheral bus.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_HALTED   | core held; JUMP and STEP accepted here only
//   ST_RUNNING  | core free-running until halt write or breakpoint
//   ST_STEPPING | core retires step_remaining more instructions, then halts
module core_run_control
    import core_debug_pkg::*;
#(
    parameter int PC_WIDTH         = 32,
    parameter int BREAKPOINT_COUNT = 2,
    parameter int STEP_WIDTH       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                peripheralEnable,
    input  logic                peripheralWriteEnable,
    input  logic [3:0]          peripheralAddress,
    input  logic [31:0]         peripheralDataWrite,
    output logic [31:0]         peripheralDataRead,
    output logic                peripheralBusy,
    input  logic                coreRetire,
    input  logic [PC_WIDTH-1:0] coreRetirePC,
    input  logic [PC_WIDTH-1:0] coreNextPC,
    output logic                coreHalt,
    output logic                coreJump,
    output logic [PC_WIDTH-1:0] coreJumpAddress,
    output logic                breakpointIrq
);

    run_state_t state, state_next;

    logic [STEP_WIDTH-1:0]       step_remaining;
    logic [STEP_WIDTH-1:0]       step_load;
    logic [63:0]                 instret;
    logic [31:0]                 instret_hi_latch;
    logic                        bp_halted;
    logic                        cmd_error;
    logic [31:0]                 read_value;

    logic [BREAKPOINT_COUNT-1:0] bp_match;
    logic [BREAKPOINT_COUNT-1:0] bp_enable;
    logic [BREAKPOINT_COUNT-1:0] bp_hit;
    logic [PC_WIDTH-1:0]         bp_address [BREAKPOINT_COUNT];

    logic bus_write, bus_read;
    logic wr_config, wr_step, wr_jump, wr_bp_ctrl, wr_instret;
    logic is_halted, last_step, bp_stop, stop_now;

    assign bus_write  = peripheralEnable & peripheralWriteEnable;
    assign bus_read   = peripheralEnable & ~peripheralWriteEnable;
    assign wr_config  = bus_write & (peripheralAddress == REG_CONFIG);
    assign wr_step    = bus_write & (peripheralAddress == REG_STEP);
    assign wr_jump    = bus_write & (peripheralAddress == REG_JUMP);
    assign wr_bp_ctrl = bus_write & (peripheralAddress == REG_BP_CTRL);
    assign wr_instret = bus_write & ((peripheralAddress == REG_INSTRET_LO) |
                                     (peripheralAddress == REG_INSTRET_HI));

    assign peripheralBusy = peripheralEnable;

    genvar g;
    generate
        for (g = 0; g < BREAKPOINT_COUNT; g++) begin : g_bp
            core_breakpoint_match #(
                .PC_WIDTH(PC_WIDTH)
            ) u_match (
                .clk        (clk),
                .rst        (rst),
                .addr_write (bus_write & (peripheralAddress == REG_BP_ADDR0 + 4'(g))),
                .addr_data  (PC_WIDTH'(peripheralDataWrite)),
                .ctrl_write (wr_bp_ctrl),
                .enable_data(peripheralDataWrite[g]),
                .clear_data (peripheralDataWrite[BP_HIT_LSB + g]),
                .retire     (coreRetire),
                .retire_pc  (coreRetirePC),
                .match      (bp_match[g]),
                .enable     (bp_enable[g]),
                .hit        (bp_hit[g]),
                .address    (bp_address[g])
            );
        end
    endgenerate

    // The terminating retire raises coreHalt in its own cycle so the core
    // cannot slip one more instruction past a breakpoint or the final step.
    assign is_halted = (state == ST_HALTED);
    assign last_step = (state == ST_STEPPING) && (step_remaining == STEP_WIDTH'(1));
    assign bp_stop   = coreRetire & ~is_halted & (|bp_match);
    assign stop_now  = bp_stop | (coreRetire & last_step);
    assign coreHalt  = is_halted | stop_now;

    assign step_load = (peripheralDataWrite[STEP_WIDTH-1:0] == '0) ?
                       STEP_WIDTH'(1) : peripheralDataWrite[STEP_WIDTH-1:0];

    always_comb begin
        state_next = state;
        case (state)
            ST_HALTED: begin
                if (wr_config && peripheralDataWrite[CFG_RUNNING]) begin
                    state_next = ST_RUNNING;
                end else if (wr_step) begin
                    state_next = ST_STEPPING;
                end
            end
            ST_RUNNING, ST_STEPPING: begin
                if (stop_now || (wr_config && !peripheralDataWrite[CFG_RUNNING])) begin
                    state_next = ST_HALTED;
                end
            end
            default: state_next = ST_HALTED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_HALTED;
            step_remaining <= '0;
        end else begin
            state <= state_next;
            if (is_halted && wr_step) begin
                step_remaining <= step_load;
            end else if ((state == ST_STEPPING) && coreRetire) begin
                step_remaining <= step_remaining - STEP_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret          <= '0;
            instret_hi_latch <= '0;
        end else begin
            if (wr_instret) begin
                instret <= '0;
            end else if (coreRetire) begin
                instret <= instret + 64'd1;
            end
            if (bus_read && (peripheralAddress == REG_INSTRET_LO)) begin
                instret_hi_latch <= instret[63:32];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_halted       <= 1'b0;
            cmd_error       <= 1'b0;
            breakpointIrq   <= 1'b0;
            coreJump        <= 1'b0;
            coreJumpAddress <= '0;
        end else begin
            breakpointIrq <= bp_stop;
            coreJump      <= wr_jump & is_halted;
            if (wr_jump && is_halted) begin
                coreJumpAddress <= PC_WIDTH'(peripheralDataWrite);
            end
            // A breakpoint halt in the same cycle as a CONFIG write still reports.
            if (bp_stop) begin
                bp_halted <= 1'b1;
            end else if (wr_config) begin
                bp_halted <= 1'b0;
            end
            if ((wr_jump || wr_step) && !is_halted) begin
                cmd_error <= 1'b1;
            end else if (wr_config) begin
                cmd_error <= 1'b0;
            end
        end
    end

    always_comb begin
        read_value = '0;
        case (peripheralAddress)
            REG_CONFIG: begin
                read_value[CFG_RUNNING]   = (state == ST_RUNNING);
                read_value[CFG_STEPPING]  = (state == ST_STEPPING);
                read_value[CFG_BP_HALT]   = bp_halted;
                read_value[CFG_CMD_ERROR] = cmd_error;
            end
            REG_PC:         read_value = 32'(coreNextPC);
            REG_INSTRET_LO: read_value = instret[31:0];
            REG_INSTRET_HI: read_value = instret_hi_latch;
            REG_BP_CTRL: begin
                for (int i = 0; i < BREAKPOINT_COUNT; i++) begin
                    read_value[i]              = bp_enable[i];
                    read_value[BP_HIT_LSB + i] = bp_hit[i];
                end
            end
            default: begin
                for (int i = 0; i < BREAKPOINT_COUNT; i++) begin
                    if (peripheralAddress == REG_BP_ADDR0 + 4'(i)) begin
                        read_value = 32'(bp_address[i]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peripheralDataRead <= '0;
        end else if (bus_read) begin
            peripheralDataRead <= read_value;
        end
    end

endmodule

// File: tb/tb_core_run_control.sv
// Bench for core_run_control: a NOP-stream core model, a register vector
// table, directed multi-cycle sequences and randomized step/breakpoint runs.
module tb_core_run_control;
    import core_debug_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        peripheralEnable = 1'b0;
    logic        peripheralWriteEnable = 1'b0;
    logic [3:0]  peripheralAddress = 4'd0;
    logic [31:0] peripheralDataWrite = 32'd0;
    logic [31:0] peripheralDataRead;
    logic        peripheralBusy;
    logic        coreRetire = 1'b0;
    logic [31:0] coreRetirePC = 32'd0;
    logic [31:0] coreNextPC = 32'd0;
    logic        coreHalt;
    logic        coreJump;
    logic [31:0] coreJumpAddress;
    logic        breakpointIrq;

    core_run_control dut (
        .clk                  (clk),
        .rst                  (rst),
        .peripheralEnable     (peripheralEnable),
        .peripheralWriteEnable(peripheralWriteEnable),
        .peripheralAddress    (peripheralAddress),
        .peripheralDataWrite  (peripheralDataWrite),
        .peripheralDataRead   (peripheralDataRead),
        .peripheralBusy       (peripheralBusy),
        .coreRetire           (coreRetire),
        .coreRetirePC         (coreRetirePC),
        .coreNextPC           (coreNextPC),
        .coreHalt             (coreHalt),
        .coreJump             (coreJump),
        .coreJumpAddress      (coreJumpAddress),
        .breakpointIrq        (breakpointIrq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Core model and event counters
    logic [31:0] core_pc = 32'd0;
    logic        last_retire = 1'b0;
    logic        last_jump = 1'b0;
    logic [31:0] last_jump_addr = 32'd0;
    logic [63:0] m_instret = 64'd0;
    int          retire_count = 0;
    int          jump_pulses = 0;
    int          irq_pulses = 0;

    always @(negedge clk) begin
        last_retire    = coreRetire;
        last_jump      = coreJump;
        last_jump_addr = coreJumpAddress;
        if (coreRetire) retire_count++;
        if (coreJump) jump_pulses++;
        if (breakpointIrq) irq_pulses++;
        if (rst)
            m_instret = 64'd0;
        else if (peripheralEnable && peripheralWriteEnable &&
                 (peripheralAddress == REG_INSTRET_LO || peripheralAddress == REG_INSTRET_HI))
            m_instret = 64'd0;
        else if (coreRetire)
            m_instret = m_instret + 64'd1;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) core_pc = 32'd0;
            else if (last_jump) core_pc = last_jump_addr;
            else if (last_retire) core_pc = core_pc + 32'd4;
            last_jump    = 1'b0;
            last_retire  = 1'b0;
            coreRetire   = 1'b0;
            coreRetirePC = core_pc;
            coreNextPC   = core_pc;
            #1;
            if (!rst && !coreHalt) coreRetire = 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        peripheralEnable      = 1'b1;
        peripheralWriteEnable = 1'b1;
        peripheralAddress     = a;
        peripheralDataWrite   = d;
        @(posedge clk);
        #1;
        peripheralEnable      = 1'b0;
        peripheralWriteEnable = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(posedge clk);
        #1;
        peripheralEnable      = 1'b1;
        peripheralWriteEnable = 1'b0;
        peripheralAddress     = a;
        #1;
        check("busy_strobe", {63'd0, peripheralBusy}, 64'd1);
        @(posedge clk);
        #1;
        peripheralEnable = 1'b0;
        d = peripheralDataRead;
        check("busy_idle", {63'd0, peripheralBusy}, 64'd0);
    endtask

    task automatic wait_halt(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (coreHalt && !coreRetire) done = 1'b1;
        end
        check({name, "_halted"}, {63'd0, done}, 64'd1);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [18];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, v1, v2;
        int rc0, jp0, irq0;

        vecs[0]  = '{1'b0, REG_CONFIG,     32'h0,         32'h0};
        vecs[1]  = '{1'b0, REG_PC,         32'h0,         32'h0};
        vecs[2]  = '{1'b0, REG_INSTRET_LO, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, REG_INSTRET_HI, 32'h0,         32'h0};
        vecs[4]  = '{1'b0, REG_BP_CTRL,    32'h0,         32'h0};
        vecs[5]  = '{1'b1, 4'd8,           32'h1234_5678, 32'h0};
        vecs[6]  = '{1'b0, 4'd8,           32'h0,         32'h1234_5678};
        vecs[7]  = '{1'b1, 4'd9,           32'hCAFE_F00C, 32'h0};
        vecs[8]  = '{1'b0, 4'd9,           32'h0,         32'hCAFE_F00C};
        vecs[9]  = '{1'b1, REG_BP_CTRL,    32'h0000_0302, 32'h0};
        vecs[10] = '{1'b0, REG_BP_CTRL,    32'h0,         32'h0000_0002};
        vecs[11] = '{1'b1, 4'd7,           32'hFFFF_FFFF, 32'h0};
        vecs[12] = '{1'b0, 4'd7,           32'h0,         32'h0};
        vecs[13] = '{1'b0, 4'd10,          32'h0,         32'h0};
        vecs[14] = '{1'b1, REG_PC,         32'h0000_0055, 32'h0};
        vecs[15] = '{1'b0, REG_PC,         32'h0,         32'h0};
        vecs[16] = '{1'b1, REG_BP_CTRL,    32'h0,         32'h0};
        vecs[17] = '{1'b0, REG_BP_CTRL,    32'h0,         32'h0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_core_halt", {63'd0, coreHalt}, 64'd1);
        check("rst_core_jump", {63'd0, coreJump}, 64'd0);
        check("rst_jump_addr", {32'd0, coreJumpAddress}, 64'd0);
        check("rst_irq", {63'd0, breakpointIrq}, 64'd0);
        check("rst_read_data", {32'd0, peripheralDataRead}, 64'd0);
        check("rst_busy", {63'd0, peripheralBusy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].we) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_reg%0d", i, vecs[i].addr), {32'd0, rd}, {32'd0, vecs[i].exp});
            end
        end

        // STEP 0 acts as a single step
        rc0 = retire_count;
        bus_write(REG_STEP, 32'd0);
        wait_halt("step0", 50);
        repeat (5) @(posedge clk);
        check("step0_retires", 64'(retire_count - rc0), 64'd1);
        bus_read(REG_PC, rd);
        check("step0_pc", {32'd0, rd}, 64'h4);
        bus_read(REG_CONFIG, rd);
        check("step0_config", {32'd0, rd}, 64'h0);

        bus_read(REG_INSTRET_LO, v1);
        rc0 = retire_count;
        bus_write(REG_STEP, 32'd5);
        wait_halt("step5", 50);
        repeat (3) @(posedge clk);
        bus_read(REG_INSTRET_LO, v2);
        check("step5_instret_delta", {32'd0, v2 - v1}, 64'd5);
        check("step5_retires", 64'(retire_count - rc0), 64'd5);

        jp0 = jump_pulses;
        bus_write(REG_JUMP, 32'h100);
        repeat (3) @(posedge clk);
        #1;
        check("jump_pulses", 64'(jump_pulses - jp0), 64'd1);
        check("jump_address", {32'd0, coreJumpAddress}, 64'h100);
        bus_read(REG_PC, rd);
        check("jump_pc", {32'd0, rd}, 64'h100);

        bus_write(4'd8, 32'h108);
        bus_write(REG_BP_CTRL, 32'h1);
        rc0 = retire_count;
        irq0 = irq_pulses;
        bus_write(REG_CONFIG, 32'h1);
        wait_halt("bp_run", 60);
        repeat (3) @(posedge clk);
        check("bp_retires", 64'(retire_count - rc0), 64'd3);
        check("bp_irq_pulses", 64'(irq_pulses - irq0), 64'd1);
        bus_read(REG_CONFIG, rd);
        check("bp_config", {32'd0, rd}, 64'h4);
        bus_read(REG_BP_CTRL, rd);
        check("bp_ctrl_hit", {32'd0, rd}, 64'h101);
        bus_read(REG_PC, rd);
        check("bp_pc", {32'd0, rd}, 64'h10C);

        // Commands while running are refused and flagged
        bus_write(REG_BP_CTRL, 32'h100);
        bus_read(REG_BP_CTRL, rd);
        check("bp_ctrl_cleared", {32'd0, rd}, 64'h0);
        bus_write(REG_CONFIG, 32'h1);
        jp0 = jump_pulses;
        bus_write(REG_JUMP, 32'h200);
        bus_write(REG_STEP, 32'd3);
        bus_read(REG_CONFIG, rd);
        check("run_cmd_error", {32'd0, rd}, 64'h9);
        check("run_jump_ignored", 64'(jump_pulses - jp0), 64'd0);
        bus_write(REG_CONFIG, 32'h0);
        wait_halt("run_halt", 20);
        bus_read(REG_CONFIG, rd);
        check("halt_config_clear", {32'd0, rd}, 64'h0);

        bus_write(REG_INSTRET_LO, 32'h0);
        bus_read(REG_INSTRET_LO, rd);
        check("instret_lo_cleared", {32'd0, rd}, 64'h0);
        bus_read(REG_INSTRET_HI, rd);
        check("instret_hi_cleared", {32'd0, rd}, 64'h0);
        bus_write(REG_CONFIG, 32'h1);
        #200;
        bus_write(REG_INSTRET_HI, 32'h0);
        #100;
        bus_write(REG_CONFIG, 32'h0);
        wait_halt("instret_run1", 20);
        bus_read(REG_INSTRET_LO, v1);
        check("instret_run1_model", {32'd0, v1}, {32'd0, m_instret[31:0]});
        check("instret_run1_gt1", {63'd0, v1 > 32'd1}, 64'd1);
        bus_write(REG_CONFIG, 32'h1);
        #200;
        bus_write(REG_CONFIG, 32'h0);
        wait_halt("instret_run2", 20);
        bus_read(REG_INSTRET_LO, v2);
        check("instret_run2_model", {32'd0, v2}, {32'd0, m_instret[31:0]});
        check("instret_run2_larger", {63'd0, v2 > v1}, 64'd1);

        // 64-bit wrap from a preloaded counter
        @(posedge clk);
        #1;
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #2;
        release dut.instret;
        bus_read(REG_INSTRET_LO, rd);
        check("preload_lo", {32'd0, rd}, 64'hFFFF_FFFF);
        bus_read(REG_INSTRET_HI, rd);
        check("preload_hi", {32'd0, rd}, 64'hFFFF_FFFF);
        bus_write(REG_STEP, 32'd1);
        wait_halt("wrap_step", 30);
        bus_read(REG_INSTRET_LO, rd);
        check("wrap_lo", {32'd0, rd}, {32'd0, m_instret[31:0]});
        bus_read(REG_INSTRET_HI, rd);
        check("wrap_hi", {32'd0, rd}, {32'd0, m_instret[63:32]});
        check("wrap_model_zero", m_instret, 64'd0);

        // Randomized jump/step/breakpoint runs against the rule-level model
        for (int it = 0; it < 40; it++) begin
            int n, j, exp_ret;
            logic [31:0] p, tgt;
            logic [63:0] m0;
            bit hit;
            bus_write(REG_CONFIG, 32'h0);
            if ($urandom_range(0, 1) == 1) begin
                tgt = 32'($urandom_range(0, 1023)) * 32'd4;
                bus_write(REG_JUMP, tgt);
                repeat (2) @(posedge clk);
                #2;
                check($sformatf("rnd%0d_jump_pc", it), {32'd0, core_pc}, {32'd0, tgt});
            end
            p = core_pc;
            n = $urandom_range(1, 10);
            j = $urandom_range(0, 11);
            hit = (j + 1 <= n);
            exp_ret = hit ? j + 1 : n;
            bus_write(4'd8, p + 32'(4 * j));
            bus_write(REG_BP_CTRL, 32'h101);
            rc0 = retire_count;
            irq0 = irq_pulses;
            m0 = m_instret;
            bus_write(REG_STEP, 32'(n));
            wait_halt($sformatf("rnd%0d", it), 60);
            repeat (2) @(posedge clk);
            check($sformatf("rnd%0d_retires", it), 64'(retire_count - rc0), 64'(exp_ret));
            check($sformatf("rnd%0d_irq", it), 64'(irq_pulses - irq0), hit ? 64'd1 : 64'd0);
            bus_read(REG_PC, rd);
            check($sformatf("rnd%0d_pc", it), {32'd0, rd}, {32'd0, p + 32'(4 * exp_ret)});
            bus_read(REG_CONFIG, rd);
            check($sformatf("rnd%0d_config", it), {32'd0, rd}, hit ? 64'h4 : 64'h0);
            bus_read(REG_BP_CTRL, rd);
            check($sformatf("rnd%0d_bp_ctrl", it), {32'd0, rd}, hit ? 64'h101 : 64'h1);
            bus_read(REG_INSTRET_LO, rd);
            check($sformatf("rnd%0d_instret", it), {32'd0, rd}, {32'd0, m0[31:0] + 32'(exp_ret)});
        end

        // Asynchronous reset in the middle of a long step
        bus_write(REG_BP_CTRL, 32'h100);
        bus_write(REG_STEP, 32'd1000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_step_halt", {63'd0, coreHalt}, 64'd1);
        check("rst_mid_step_jump", {63'd0, coreJump}, 64'd0);
        check("rst_mid_step_irq", {63'd0, breakpointIrq}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus_read(REG_CONFIG, rd);
        check("rst_mid_step_config", {32'd0, rd}, 64'h0);
        bus_read(REG_INSTRET_LO, rd);
        check("rst_mid_step_instret", {32'd0, rd}, 64'h0);
        rc0 = retire_count;
        repeat (10) @(posedge clk);
        check("rst_mid_step_no_retire", 64'(retire_count - rc0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
